// File: rtl/pe_fx_mac.sv
// Fixed-point processing element: weight memory, input-reuse buffer,
// single-cycle MAC, bias add, ReLU/identity activation with saturation.
module pe_fx_mac #(
    parameter int DW       = 16,
    parameter int FRAC     = 8,
    parameter int AW       = 40,
    parameter int DEPTH    = 64,
    parameter int ACT_RELU = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    ctrl,
    input  logic          output_ctrl,
    input  logic [DW-1:0] data_in,
    input  logic          in_valid,
    output logic [DW-1:0] data_out,
    output logic          out_valid,
    output logic          buf_done,
    output logic          err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic signed [AW-1:0] SMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        M_IDLE, M_LOAD, M_MA, M_MAB, M_MABO, M_BIAS, M_ACT, M_ACT_CLR
    } mode_t;

    mode_t mode;
    mode_t prev_mode;

    logic [DW-1:0] wmem [DEPTH];
    logic [DW-1:0] ibuf [DEPTH];

    logic signed [AW-1:0] acc;
    logic [CW-1:0] wgt_cnt;
    logic [CW-1:0] buf_cnt;
    logic [CW-1:0] bptr;
    logic [PW-1:0] rd_ptr;
    logic [DW-1:0] res_reg;
    logic          res_vld;

    logic                   entry;
    logic                   is_buf;
    logic                   consume;
    logic                   ma_op;
    logic                   we_w;
    logic                   we_b;
    logic [CW-1:0]          wc;
    logic [CW-1:0]          bptr_eff;
    logic [CW-1:0]          rd_nxt;
    logic [PW-1:0]          rd_wrap;
    logic [DW-1:0]          w_rd;
    logic [DW-1:0]          b_rd;
    logic [DW-1:0]          mul_a;
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   prod_x;
    logic signed [AW-1:0]   bias_x;
    logic signed [AW-1:0]   shv;
    logic signed [AW-1:0]   actv;
    logic [DW-1:0]          sat_v;

    assign mode  = mode_t'(ctrl);
    assign entry = (mode != prev_mode);

    // A fresh MAB/MABO pass and a fresh weight set both start at index 0
    assign bptr_eff = entry ? '0 : bptr;
    assign wc       = (mode == M_LOAD && entry) ? '0 : wgt_cnt;

    assign is_buf   = (mode == M_MAB) || (mode == M_MABO);
    assign buf_done = is_buf && (bptr_eff == buf_cnt);
    assign consume  = is_buf && !buf_done;
    assign ma_op    = (mode == M_MA) && in_valid;

    assign we_w = !rst && mode == M_LOAD && in_valid && wc != CW'(DEPTH);
    assign we_b = !rst && ma_op && buf_cnt != CW'(DEPTH);

    assign w_rd   = wmem[rd_ptr];
    assign b_rd   = ibuf[bptr_eff[PW-1:0]];
    assign mul_a  = ma_op ? data_in : b_rd;
    assign prod   = $signed(mul_a) * $signed(w_rd);
    assign prod_x = AW'(prod);
    assign bias_x = AW'($signed(data_in)) <<< FRAC;

    assign rd_nxt  = CW'(rd_ptr) + CW'(1);
    assign rd_wrap = (rd_nxt == wgt_cnt) ? '0 : rd_nxt[PW-1:0];

    always_comb begin
        shv  = acc >>> FRAC;
        actv = (ACT_RELU != 0 && shv[AW-1]) ? '0 : shv;
        if (actv > SMAX)
            sat_v = SMAX[DW-1:0];
        else if (actv < SMIN)
            sat_v = SMIN[DW-1:0];
        else
            sat_v = actv[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (we_w) wmem[wc[PW-1:0]] <= data_in;
        if (we_b) ibuf[buf_cnt[PW-1:0]] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            wgt_cnt   <= '0;
            buf_cnt   <= '0;
            bptr      <= '0;
            rd_ptr    <= '0;
            res_reg   <= '0;
            res_vld   <= 1'b0;
            data_out  <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            prev_mode <= M_IDLE;
        end else begin
            prev_mode <= mode;

            if (mode == M_MABO) begin
                out_valid <= consume;
                if (consume) data_out <= b_rd;
            end else begin
                data_out  <= res_reg;
                out_valid <= res_vld & output_ctrl;
            end

            unique case (mode)
                M_LOAD: begin
                    if (entry) rd_ptr <= '0;
                    if (in_valid && wc == CW'(DEPTH)) err <= 1'b1;
                    wgt_cnt <= we_w ? wc + CW'(1) : wc;
                end
                M_MA: begin
                    res_vld <= 1'b0;
                    if (in_valid) begin
                        if (wgt_cnt != '0) begin
                            acc    <= acc + prod_x;
                            rd_ptr <= rd_wrap;
                        end
                        if (buf_cnt == CW'(DEPTH)) err <= 1'b1;
                        else buf_cnt <= buf_cnt + CW'(1);
                    end
                end
                M_MAB, M_MABO: begin
                    res_vld <= 1'b0;
                    bptr    <= bptr_eff;
                    if (consume) begin
                        bptr <= bptr_eff + CW'(1);
                        if (wgt_cnt != '0) begin
                            acc    <= acc + prod_x;
                            rd_ptr <= rd_wrap;
                        end
                    end
                end
                M_BIAS: begin
                    res_vld <= 1'b0;
                    if (in_valid) acc <= acc + bias_x;
                end
                M_ACT, M_ACT_CLR: begin
                    res_reg <= sat_v;
                    res_vld <= 1'b1;
                    acc     <= '0;
                    rd_ptr  <= '0;
                    if (mode == M_ACT_CLR) buf_cnt <= '0;
                end
                M_IDLE: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pe_fx_mac.sv
// Bench for pe_fx_mac: ReLU and identity instances share stimulus,
// checked every cycle against a plain-arithmetic reference model.
module tb_pe_fx_mac;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  ctrl = 3'd0;
    logic        output_ctrl = 1'b0;
    logic [15:0] data_in = 16'h0;
    logic        in_valid = 1'b0;

    logic [15:0] dout_r, dout_l;
    logic        ov_r, ov_l, bd_r, bd_l, err_r, err_l;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pe_fx_mac #(.DW(16), .FRAC(8), .AW(40), .DEPTH(DEPTH), .ACT_RELU(1)) u_relu (
        .clk(clk), .rst(rst), .ctrl(ctrl), .output_ctrl(output_ctrl),
        .data_in(data_in), .in_valid(in_valid), .data_out(dout_r),
        .out_valid(ov_r), .buf_done(bd_r), .err(err_r)
    );

    pe_fx_mac #(.DW(16), .FRAC(8), .AW(40), .DEPTH(DEPTH), .ACT_RELU(0)) u_lin (
        .clk(clk), .rst(rst), .ctrl(ctrl), .output_ctrl(output_ctrl),
        .data_in(data_in), .in_valid(in_valid), .data_out(dout_l),
        .out_valid(ov_l), .buf_done(bd_l), .err(err_l)
    );

    // reference model state
    longint w [DEPTH];
    longint b [DEPTH];
    int     wcnt, bcnt, rd, bptr, pm;
    longint acc;
    longint res_relu, res_lin;
    bit     rvld;
    longint exp_do_r, exp_do_l;
    bit     exp_ov, exp_err, just_rst, armed;

    function automatic longint sx(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint wrap40(input longint x);
        return (x <<< 24) >>> 24;
    endfunction

    function automatic longint sat16(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        int m, ebp;
        bit cons;
        m = int'(ctrl);
        if (rst) begin
            wcnt = 0; bcnt = 0; rd = 0; bptr = 0; pm = 0; acc = 0;
            res_relu = 0; res_lin = 0; rvld = 0;
            exp_do_r = 0; exp_do_l = 0; exp_ov = 0; exp_err = 0;
            just_rst = 1; armed = 1;
        end else begin
            just_rst = 0;
            ebp  = (m != pm) ? 0 : bptr;
            cons = (ebp < bcnt);
            if (m == 4) begin
                exp_ov = cons;
                if (cons) begin
                    exp_do_r = b[ebp];
                    exp_do_l = b[ebp];
                end
            end else begin
                exp_do_r = res_relu;
                exp_do_l = res_lin;
                exp_ov   = rvld && output_ctrl;
            end
            case (m)
                1: begin
                    if (m != pm) begin wcnt = 0; rd = 0; end
                    if (in_valid) begin
                        if (wcnt == DEPTH) exp_err = 1;
                        else begin w[wcnt] = sx(data_in); wcnt++; end
                    end
                end
                2: begin
                    rvld = 0;
                    if (in_valid) begin
                        if (wcnt > 0) begin
                            acc = wrap40(acc + sx(data_in) * w[rd]);
                            rd = (rd + 1) % wcnt;
                        end
                        if (bcnt < DEPTH) begin b[bcnt] = sx(data_in); bcnt++; end
                        else exp_err = 1;
                    end
                end
                3, 4: begin
                    rvld = 0;
                    bptr = ebp;
                    if (cons) begin
                        if (wcnt > 0) begin
                            acc = wrap40(acc + b[bptr] * w[rd]);
                            rd = (rd + 1) % wcnt;
                        end
                        bptr++;
                    end
                end
                5: begin
                    rvld = 0;
                    if (in_valid) acc = wrap40(acc + sx(data_in) * 256);
                end
                6, 7: begin
                    res_lin  = sat16(acc >>> 8) & 16'hFFFF;
                    res_relu = sat16((acc < 0) ? 0 : (acc >>> 8)) & 16'hFFFF;
                    rvld = 1; acc = 0; rd = 0;
                    if (m == 7) bcnt = 0;
                end
                default: ;
            endcase
            pm = m;
        end
    end

    always @(negedge clk) begin : compare
        int m, ebp;
        bit ebd;
        if (armed) begin
            m   = int'(ctrl);
            ebp = (m != pm) ? 0 : bptr;
            ebd = (ebp == bcnt);
            if (!rst && (m == 3 || m == 4)) begin
                chk("buf_done_relu", 64'(bd_r), 64'(ebd));
                chk("buf_done_lin", 64'(bd_l), 64'(ebd));
            end
            chk("out_valid_relu", 64'(ov_r), 64'(exp_ov));
            chk("out_valid_lin", 64'(ov_l), 64'(exp_ov));
            chk("err_relu", 64'(err_r), 64'(exp_err));
            chk("err_lin", 64'(err_l), 64'(exp_err));
            if (exp_ov || just_rst) begin
                chk("data_out_relu", 64'(dout_r), 64'(exp_do_r & 16'hFFFF));
                chk("data_out_lin", 64'(dout_l), 64'(exp_do_l & 16'hFFFF));
            end
        end
    end

    task automatic cyc(input logic [2:0] c, input logic oc = 1'b0,
                       input logic [15:0] d = 16'h0, input logic v = 1'b0);
        ctrl = c; output_ctrl = oc; data_in = d; in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(3'd0);
        rst = 1'b0;
    endtask

    task automatic result(input string nm, input logic [15:0] er, input logic [15:0] el);
        cyc(3'd0, 1'b1);
        chk({nm, "_relu"}, 64'(dout_r), 64'(er));
        chk({nm, "_lin"}, 64'(dout_l), 64'(el));
        chk({nm, "_vld"}, 64'(ov_r), 64'(1));
    endtask

    initial begin
        do_reset();
        chk("rst_dout", 64'(dout_r), 64'h0);
        chk("rst_err", 64'(err_r), 64'h0);

        // 2.0 * 4.0
        cyc(3'd1, 0, 16'h0200, 1);
        cyc(3'd2, 0, 16'h0400, 1);
        cyc(3'd6);
        chk("idle_no_vld", 64'(ov_r), 64'h0);
        result("t1", 16'h0800, 16'h0800);

        // three weights, bias -1.0, then replay the buffer
        cyc(3'd7);
        cyc(3'd1, 0, 16'h0100, 1);
        cyc(3'd1, 0, 16'h0200, 1);
        cyc(3'd1, 0, 16'h0300, 1);
        for (int i = 0; i < 3; i++) cyc(3'd2, 0, 16'h0100, 1);
        cyc(3'd5, 0, 16'hFF00, 1);
        cyc(3'd6);
        result("t2", 16'h0500, 16'h0500);
        for (int i = 0; i < 3; i++) begin
            cyc(3'd3);
            chk("mab_busy", 64'(bd_r), 64'(i == 2));
        end
        cyc(3'd3);
        chk("mab_done", 64'(bd_r), 64'h1);
        cyc(3'd6);
        result("t2b", 16'h0600, 16'h0600);

        // negative product through ReLU vs identity
        cyc(3'd7);
        cyc(3'd1, 0, 16'hFE00, 1);
        cyc(3'd2, 0, 16'h0100, 1);
        cyc(3'd6);
        result("t3", 16'h0000, 16'hFE00);

        // saturation both ways
        cyc(3'd7);
        cyc(3'd1, 0, 16'h7FFF, 1);
        for (int i = 0; i < 4; i++) cyc(3'd2, 0, 16'h7FFF, 1);
        cyc(3'd6);
        result("t4p", 16'h7FFF, 16'h7FFF);
        cyc(3'd7);
        cyc(3'd1, 0, 16'h8001, 1);
        for (int i = 0; i < 4; i++) cyc(3'd2, 0, 16'h7FFF, 1);
        cyc(3'd6);
        result("t4n", 16'h0000, 16'h8000);
        chk("no_err_yet", 64'(err_r), 64'h0);

        // weight memory overflow
        for (int i = 0; i < 5; i++) cyc(3'd1, 0, 16'h0100, 1);
        cyc(3'd0);
        chk("wovf_err", 64'(err_r), 64'h1);

        // buffer overflow keeps accumulating
        do_reset();
        chk("err_cleared", 64'(err_l), 64'h0);
        cyc(3'd1, 0, 16'h0100, 1);
        for (int i = 0; i < 5; i++) cyc(3'd2, 0, 16'h0100, 1);
        chk("bovf_err", 64'(err_r), 64'h1);
        cyc(3'd6);
        result("t5", 16'h0500, 16'h0500);

        // MABO forwarding, reset mid-pass, empty buffer after ACT_CLR
        do_reset();
        cyc(3'd1, 0, 16'h0100, 1);
        cyc(3'd2, 0, 16'h0111, 1);
        cyc(3'd2, 0, 16'h0222, 1);
        cyc(3'd2, 0, 16'h0333, 1);
        cyc(3'd4);
        chk("mabo0", 64'(dout_l), 64'h0111);
        chk("mabo0_vld", 64'(ov_l), 64'h1);
        cyc(3'd4);
        chk("mabo1", 64'(dout_r), 64'h0222);
        rst = 1'b1;
        cyc(3'd4);
        rst = 1'b0;
        chk("mid_rst_dout", 64'(dout_r), 64'h0);
        chk("mid_rst_vld", 64'(ov_r), 64'h0);
        cyc(3'd2, 0, 16'h0100, 1);
        cyc(3'd7);
        ctrl = 3'd3;
        #1;
        chk("clr_buf_done", 64'(bd_r), 64'h1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [2:0]  c;
            logic [15:0] d;
            c = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0)
                d = 16'($urandom);
            else
                d = 16'($urandom_range(0, 1023)) - 16'd512;
            if ($urandom_range(0, 79) == 0) rst = 1'b1;
            cyc(c, 1'($urandom), d, 1'($urandom_range(0, 3) != 0));
            rst = 1'b0;
        end
        cyc(3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pe_fx_mac.md
Name: pe_fx_mac

Overview:
- Parametrised fixed-point processing element. It is the next generation of the array-processor PE and uses the same 3-bit control encoding.
- It holds a local weight memory and an input-reuse buffer, and does single-cycle multiply-accumulate, bias add, and activation with output saturation.
- It sits in the array_processor under the array controller, which drives `ctrl` and `output_ctrl` to each PE.

Parameters:
- DW, 16: signed data/weight width (two's complement).
- FRAC, 8: fractional bits of the data/weight Q format.
- AW, 40: accumulator width (AW >= 2*DW).
- DEPTH, 64: entries in the weight memory and in the input buffer (power of 2).
- ACT_RELU, 1: 1 = ReLU before saturation; 0 = identity.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ctrl  in  3  mode: 0 IDLE, 1 LOAD, 2 MA, 3 MAB, 4 MABO, 5 BIAS, 6 ACT, 7 ACT_CLR.
- output_ctrl  in  1  output enable for the result.
- data_in  in  DW  operand/weight/bias input.
- in_valid  in  1  qualifies data_in.
- data_out  out  DW  result word, or forwarded buffer word in MABO.
- out_valid  out  1  qualifies data_out.
- buf_done  out  1  MAB/MABO has consumed every buffered entry.
- err  out  1  sticky overflow flag: write to a full weight memory or full buffer.

Behaviour:
- Reset (rst=1 at a clk edge):
  - acc=0, wgt_cnt=0, buf_cnt=0, rd_ptr=0, res_reg=0, res_vld=0.
  - data_out=0, out_valid=0, buf_done=0, err=0.
  - Memory contents are don't-care.
  - Reset mid-operation aborts the operation; there is no partial completion.
- All state updates on the rising clk edge. MAC latency is 1 cycle: acc reflects an operand on the edge that samples it.
- IDLE: no state change.
- LOAD:
  - On the first LOAD cycle after any non-LOAD mode: wgt_cnt:=0, rd_ptr:=0 (new weight set).
  - Each in_valid cycle writes wmem[wgt_cnt]=data_in and increments wgt_cnt.
  - If wgt_cnt==DEPTH, the write is dropped and err:=1.
- MA: each in_valid cycle does, in parallel:
  - acc += sext(data_in*wmem[rd_ptr]);
  - if buf_cnt<DEPTH: ibuf[buf_cnt]=data_in and buf_cnt++; otherwise err:=1;
  - rd_ptr := (rd_ptr+1==wgt_cnt) ? 0 : rd_ptr+1.
- Empty weight set: MA/MAB/MABO with wgt_cnt==0 do not change acc.
- MAB:
  - Runs without in_valid, one entry per cycle: acc += ibuf[bptr]*wmem[rd_ptr]; bptr++; rd_ptr wraps as in MA.
  - bptr resets to 0 on entry into MAB/MABO from any other mode.
  - When bptr==buf_cnt, it stalls and buf_done=1. buf_done is combinational, valid only in MAB/MABO.
  - buf_cnt==0 means buf_done immediately and acc unchanged.
- MABO:
  - Same as MAB, and also data_out=ibuf[bptr], out_valid=1 for each consumed entry, registered (appears 1 cycle after the read).
  - output_ctrl is ignored in MABO.
- BIAS: each in_valid cycle does acc += sext(data_in) << FRAC.
- ACT:
  - res_reg := sat_DW(act(acc >>> FRAC)); arithmetic shift, truncation toward -inf.
  - act = ReLU when ACT_RELU=1: negative values become 0.
  - sat clamps to [-2^(DW-1), 2^(DW-1)-1].
  - res_vld:=1, acc:=0, rd_ptr:=0.
  - If held for several cycles, the first cycle computes; later cycles see acc=0 and overwrite res_reg with 0.
- ACT_CLR: same as ACT, and also buf_cnt:=0.
- Accumulator arithmetic: the product is 2*DW signed, sign-extended to AW. The accumulator wraps modulo 2^AW; there is no saturation inside acc.
- Output:
  - Outside MABO: data_out=res_reg and out_valid=res_vld&output_ctrl, registered with 1-cycle latency.
  - res_vld clears on the first MA/MAB/MABO/BIAS cycle.
- Illegal combinations cannot occur; ctrl is a single encoded mode.

Test Plan:
- LOAD w=0x0200 (2.0); MA x=0x0400 (4.0); ACT; IDLE with output_ctrl=1 → data_out=0x0800 (8.0), out_valid=1 one cycle after output_ctrl rises.
- LOAD 3 weights {0x0100, 0x0200, 0x0300}; MA 3 samples 0x0100 each; BIAS 0xFF00 (-1.0); ACT → 0x0500. Then MAB → 3 cycles, then buf_done=1, acc=6.0.
- MA x=0x0100, w=0xFE00 (-2.0); ACT with ACT_RELU=1 → res 0x0000. With ACT_RELU=0 → 0xFE00.
- MA 0x7FFF*0x7FFF accumulated 4×; ACT → 0x7FFF (saturated). Negative mirror case → 0x8000 with ACT_RELU=0.
- DEPTH=4: LOAD 5 words → err=1, wgt_cnt=4. Buffer overflow via 5 MA samples → err=1, and acc still includes the 5th product.
- MABO after 3 buffered samples → data_out sequence equals samples in order with out_valid pulses. Assert rst mid-MABO → all outputs 0 on the next cycle. ACT_CLR then MAB → buf_done immediately.
